// File: rtl/parity_frame_gen_chk.sv
// Word-stream parity generator/checker: registered per-word parity plus frame parity
// over FRAME_LEN accepted words, with optional check against a received parity bit.
module parity_frame_gen_chk #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned ERR_CNT_W = 8,
  localparam int unsigned IDX_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 odd_mode,
  input  logic                 chk_en,
  input  logic                 frame_clr,
  input  logic                 err_clr,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_parity,
  output logic                 beat_valid,
  output logic                 beat_parity,
  output logic                 frame_valid,
  output logic                 frame_parity,
  output logic                 parity_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [IDX_W-1:0]     beat_idx
);

  localparam logic [IDX_W-1:0]     LastIdx = IDX_W'(FRAME_LEN - 1);
  localparam logic [ERR_CNT_W-1:0] ErrMax  = '1;

  logic                 acc_q;
  logic                 odd_lat_q;
  logic                 chk_lat_q;
  logic                 word_par;
  logic                 first_beat;
  logic                 last_beat;
  logic                 frame_odd;
  logic                 frame_chk;
  logic                 acc_d;
  logic                 frame_par_d;
  logic                 mismatch;
  logic [ERR_CNT_W-1:0] err_base;
  logic [ERR_CNT_W-1:0] err_count_d;

  always_comb begin
    word_par    = ^in_data;
    first_beat  = (beat_idx == '0);
    last_beat   = (beat_idx == LastIdx);
    // On the first beat the mode is taken live so a one-word frame sees it too.
    frame_odd   = first_beat ? odd_mode : odd_lat_q;
    frame_chk   = first_beat ? chk_en : chk_lat_q;
    acc_d       = first_beat ? word_par : (acc_q ^ word_par);
    frame_par_d = acc_d ^ frame_odd;
    mismatch    = in_valid && !frame_clr && last_beat && frame_chk &&
                  (frame_par_d != in_parity);
    // Clear applies before a same-edge increment.
    err_base    = err_clr ? '0 : err_count;
    err_count_d = err_base;
    if (mismatch && (err_base != ErrMax)) begin
      err_count_d = err_base + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_valid   <= 1'b0;
      beat_parity  <= 1'b0;
      frame_valid  <= 1'b0;
      frame_parity <= 1'b0;
      parity_err   <= 1'b0;
      err_count    <= '0;
      beat_idx     <= '0;
      acc_q        <= 1'b0;
      odd_lat_q    <= 1'b0;
      chk_lat_q    <= 1'b0;
    end else begin
      beat_valid  <= 1'b0;
      frame_valid <= 1'b0;
      parity_err  <= 1'b0;
      err_count   <= err_count_d;
      if (frame_clr) begin
        beat_idx <= '0;
        acc_q    <= 1'b0;
      end else if (in_valid) begin
        beat_valid  <= 1'b1;
        beat_parity <= word_par ^ odd_mode;
        acc_q       <= acc_d;
        if (first_beat) begin
          odd_lat_q <= odd_mode;
          chk_lat_q <= chk_en;
        end
        if (last_beat) begin
          beat_idx     <= '0;
          frame_valid  <= 1'b1;
          frame_parity <= frame_par_d;
          parity_err   <= mismatch;
        end else begin
          beat_idx <= beat_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_gen_chk.sv
// Directed bench for parity_frame_gen_chk: main instance (FRAME_LEN=4, 2-bit error counter)
// plus a FRAME_LEN=1 instance sharing the same stimulus.
module tb_parity_frame_gen_chk;

  logic       clk = 1'b0;
  logic       rst, odd_mode, chk_en, frame_clr, err_clr, in_valid, in_parity;
  logic [7:0] in_data;

  logic       beat_valid, beat_parity, frame_valid, frame_parity, parity_err;
  logic [1:0] err_count;
  logic [1:0] beat_idx;

  logic       f1_bv, f1_bp, f1_fv, f1_fp, f1_pe;
  logic [7:0] f1_ec;
  logic [0:0] f1_idx;

  int n_checks = 0;
  int n_fail   = 0;
  int fv_cnt   = 0;

  always #5 clk = ~clk;

  parity_frame_gen_chk #(.DATA_W(8), .FRAME_LEN(4), .ERR_CNT_W(2)) dut (
    .clk(clk), .rst(rst), .odd_mode(odd_mode), .chk_en(chk_en), .frame_clr(frame_clr),
    .err_clr(err_clr), .in_valid(in_valid), .in_data(in_data), .in_parity(in_parity),
    .beat_valid(beat_valid), .beat_parity(beat_parity), .frame_valid(frame_valid),
    .frame_parity(frame_parity), .parity_err(parity_err), .err_count(err_count),
    .beat_idx(beat_idx)
  );

  parity_frame_gen_chk #(.DATA_W(8), .FRAME_LEN(1), .ERR_CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .odd_mode(odd_mode), .chk_en(chk_en), .frame_clr(frame_clr),
    .err_clr(err_clr), .in_valid(in_valid), .in_data(in_data), .in_parity(in_parity),
    .beat_valid(f1_bv), .beat_parity(f1_bp), .frame_valid(f1_fv),
    .frame_parity(f1_fp), .parity_err(f1_pe), .err_count(f1_ec), .beat_idx(f1_idx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (frame_valid === 1'b1) fv_cnt++;
  endtask

  // Present one word for one edge, then check the beat outputs.
  task automatic word(input logic [7:0] d, input logic ip, input logic exp_bp,
                      input logic exp_fv, input logic [1:0] exp_idx);
    in_valid  = 1'b1;
    in_data   = d;
    in_parity = ip;
    step();
    in_valid  = 1'b0;
    check("beat_valid", beat_valid, 1);
    check("beat_parity", beat_parity, exp_bp);
    check("frame_valid", frame_valid, exp_fv);
    check("beat_idx", beat_idx, exp_idx);
    check("f1_frame_valid", f1_fv, 1);
    check("f1_frame_parity", f1_fp, exp_bp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check("idle_beat_valid", beat_valid, 0);
      check("idle_frame_valid", frame_valid, 0);
    end
  endtask

  // Even-mode check frame 01,00,00,00 (computed parity 1) with received parity ip.
  task automatic chk_frame(input logic ip, input logic clr_last, input logic exp_err,
                           input logic [1:0] exp_cnt);
    word(8'h01, 1'b0, 1'b1, 1'b0, 2'd1);
    word(8'h00, 1'b0, 1'b0, 1'b0, 2'd2);
    word(8'h00, 1'b0, 1'b0, 1'b0, 2'd3);
    err_clr = clr_last;
    word(8'h00, ip, 1'b0, 1'b1, 2'd0);
    err_clr = 1'b0;
    check("chk_frame_parity", frame_parity, 1);
    check("parity_err", parity_err, exp_err);
    check("err_count", err_count, exp_cnt);
  endtask

  initial begin
    rst = 1'b1; odd_mode = 1'b0; chk_en = 1'b0; frame_clr = 1'b0; err_clr = 1'b0;
    in_valid = 1'b1; in_data = 8'hFF; in_parity = 1'b0;

    // 1. Reset held two cycles with a valid word present.
    step();
    step();
    check("rst_beat_valid", beat_valid, 0);
    check("rst_beat_parity", beat_parity, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_frame_parity", frame_parity, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_err_count", err_count, 0);
    check("rst_beat_idx", beat_idx, 0);
    check("rst_f1_valid", f1_fv, 0);
    check("rst_f1_err", {f1_pe, f1_ec, f1_idx, f1_bv, f1_bp}, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    idle(1);

    // 2. Even generate, back-to-back: 6 ones -> frame parity 0.
    fv_cnt = 0;
    word(8'h00, 1'b0, 1'b0, 1'b0, 2'd1);
    word(8'h01, 1'b0, 1'b1, 1'b0, 2'd2);
    word(8'h03, 1'b0, 1'b0, 1'b0, 2'd3);
    word(8'h07, 1'b0, 1'b1, 1'b1, 2'd0);
    check("even_frame_parity", frame_parity, 0);
    idle(1);
    check("even_frame_count", fv_cnt, 1);

    // 3. Odd generate with gaps; odd_mode dropped for the last word only affects its beat.
    // 22 ones -> even accumulator, latched odd -> frame parity 1.
    fv_cnt = 0;
    odd_mode = 1'b1;
    word(8'h0F, 1'b0, 1'b1, 1'b0, 2'd1);
    idle(2);
    word(8'h1F, 1'b0, 1'b0, 1'b0, 2'd2);
    idle(2);
    word(8'h3F, 1'b0, 1'b1, 1'b0, 2'd3);
    idle(2);
    odd_mode = 1'b0;
    word(8'h7F, 1'b0, 1'b1, 1'b1, 2'd0);
    check("odd_frame_parity", frame_parity, 1);
    idle(2);
    check("odd_frame_count", fv_cnt, 1);
    check("odd_parity_hold", frame_parity, 1);

    // 4. Check mode: mismatch then match.
    chk_en = 1'b1;
    chk_frame(1'b0, 1'b0, 1'b1, 2'd1);
    idle(1);
    check("err_pulse_gone", parity_err, 0);
    chk_frame(1'b1, 1'b0, 1'b0, 2'd1);
    chk_en = 1'b0;

    // 5. Abort mid-frame, then a full frame of 9 ones -> parity 1.
    fv_cnt = 0;
    word(8'h01, 1'b0, 1'b1, 1'b0, 2'd1);
    word(8'h01, 1'b0, 1'b1, 1'b0, 2'd2);
    frame_clr = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hFF;
    step();
    frame_clr = 1'b0;
    in_valid = 1'b0;
    check("clr_beat_valid", beat_valid, 0);
    check("clr_frame_valid", frame_valid, 0);
    check("clr_beat_idx", beat_idx, 0);
    check("clr_f1_frame_valid", f1_fv, 0);
    check("clr_err_count_kept", err_count, 1);
    word(8'hFF, 1'b0, 1'b0, 1'b0, 2'd1);
    word(8'h00, 1'b0, 1'b0, 1'b0, 2'd2);
    word(8'h00, 1'b0, 1'b0, 1'b0, 2'd3);
    word(8'h01, 1'b0, 1'b1, 1'b1, 2'd0);
    check("abort_frame_parity", frame_parity, 1);
    check("abort_frame_count", fv_cnt, 1);

    // 6. Saturation with a 2-bit counter.
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("err_clr_start", err_count, 0);
    chk_en = 1'b1;
    chk_frame(1'b0, 1'b0, 1'b1, 2'd1);
    chk_frame(1'b0, 1'b0, 1'b1, 2'd2);
    chk_frame(1'b0, 1'b0, 1'b1, 2'd3);
    chk_frame(1'b0, 1'b0, 1'b1, 2'd3);
    chk_frame(1'b0, 1'b0, 1'b1, 2'd3);
    chk_frame(1'b0, 1'b1, 1'b1, 2'd1);
    chk_en = 1'b0;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("err_clr_alone", err_count, 0);

    // Reset mid-frame discards the partial frame.
    fv_cnt = 0;
    word(8'h01, 1'b0, 1'b1, 1'b0, 2'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_beat_idx", beat_idx, 0);
    check("midrst_frame_parity", frame_parity, 0);
    word(8'h01, 1'b0, 1'b1, 1'b0, 2'd1);
    word(8'h00, 1'b0, 1'b0, 1'b0, 2'd2);
    word(8'h00, 1'b0, 1'b0, 1'b0, 2'd3);
    word(8'h00, 1'b0, 1'b0, 1'b1, 2'd0);
    check("midrst_new_parity", frame_parity, 1);
    check("midrst_frame_count", fv_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_frame_gen_chk.md
Name: parity_frame_gen_chk

Overview:
- Parametrised successor to the team's 8-bit combinational parity generator.
- Registered per-word parity plus frame-level parity accumulated over FRAME_LEN accepted words.
- Selectable even/odd sense.
- Optional check mode compares the computed frame parity against a received parity bit and keeps a saturating error count.
- Sits on a word-stream datapath, ahead of a serialiser (generate) or behind a deserialiser (check).

Parameters:
- DATA_W, 8, width of each data word (>=1).
- FRAME_LEN, 4, accepted words per frame (>=1).
- ERR_CNT_W, 8, width of saturating parity error counter (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- odd_mode  input  1  0 = even parity, 1 = odd parity.
- chk_en  input  1  1 = check mode on the frame's last word.
- frame_clr  input  1  synchronous abort of the current frame.
- err_clr  input  1  synchronous clear of err_count.
- in_valid  input  1  word present this cycle.
- in_data  input  DATA_W  data word.
- in_parity  input  1  received frame parity; sampled only on the last word of a frame.
- beat_valid  output  1  one-cycle pulse, one cycle after each accepted word.
- beat_parity  output  1  parity of that word.
- frame_valid  output  1  one-cycle pulse, one cycle after a frame's last word.
- frame_parity  output  1  parity of the completed frame.
- parity_err  output  1  one-cycle pulse, coincident with frame_valid, on a check mismatch.
- err_count  output  ERR_CNT_W  saturating mismatch count.
- beat_idx  output  clog2(FRAME_LEN), min 1  index of the next word within the frame.

Behaviour:
- **Reset (rst=1 at an edge):** every output is 0, the accumulator is 0, and the latched mode is 0.
  - rst has priority over everything.
- **Word acceptance:** a word is accepted on any edge with in_valid=1 and no rst/frame_clr.
  - There is no backpressure: every valid word is accepted.
  - Idle cycles (in_valid=0) leave all state unchanged and deassert the pulse outputs.
- **Per-word parity:** beat_parity = XOR-reduce(in_data) XOR live odd_mode, registered.
  - Latency 1: beat_valid pulses the cycle after acceptance.
- **Beat counter:** beat_idx counts accepted words 0..FRAME_LEN-1 and wraps to 0 after the last word.
- **First word (beat_idx=0):**
  - Accumulator loads XOR-reduce(in_data); it does not XOR with the stale value.
  - odd_mode and chk_en are latched for the whole frame. Changes mid-frame affect only beat_parity.
- **Middle words:** accumulator ^= XOR-reduce(in_data).
- **Last word (beat_idx=FRAME_LEN-1):** on the next cycle:
  - frame_valid=1.
  - frame_parity = final accumulator XOR latched odd_mode.
  - If latched chk_en=1 and frame_parity != in_parity (sampled with the last word): parity_err=1 and err_count increments.
  - err_count saturates at 2^ERR_CNT_W-1.
- **FRAME_LEN=1:** every word is both first and last; frame_parity equals beat_parity.
- **frame_parity hold:** frame_parity holds its value until the next frame completes. parity_err is a pulse only.
- **frame_clr:**
  - Zeroes beat_idx and the accumulator. Any in_valid word that cycle is discarded: no beat_valid, no frame_valid.
  - err_count is unaffected.
- **err_clr:** zeroes err_count.
  - If an increment occurs on the same edge, the result is 1 (the clear applies first, then the increment).
- **Priority:** rst > frame_clr > in_valid; err_clr is independent of frame_clr.
- **Reset mid-frame:** the partial frame is discarded; the next accepted word is beat 0.

Test Plan:
All scenarios use DATA_W=8, FRAME_LEN=4.
1. Reset: hold rst 2 cycles with in_valid=1, in_data=FF -> all outputs 0, beat_idx=0, no pulses.
2. Even generate: words 00,01,03,07 back-to-back, odd_mode=0 -> beat_parity 0,1,0,1; one frame_valid with frame_parity=0 (6 ones); beat_idx returns to 0.
3. Odd generate with gaps: words 0F,1F,3F,7F separated by 2 idle cycles, odd_mode=1 -> beat_parity 1,0,1,0; frame_parity=1 (22 ones); frame_valid fires exactly once; odd_mode toggled mid-frame does not change frame_parity.
4. Check: chk_en=1, even, words 01,00,00,00 with in_parity=0 -> parity_err=1, err_count=1. Repeat with in_parity=1 -> no error, err_count stays 1.
5. Abort: two words 01,01, then frame_clr with in_valid=1, then FF,00,00,01 -> no frame_valid for the aborted frame; a single frame_valid with frame_parity=1 (9 ones); beat_idx=0 after.
6. Saturation: ERR_CNT_W=2, five mismatching frames -> err_count 1,2,3,3,3. err_clr on the same edge as a sixth mismatch -> err_count=1. A later err_clr alone -> 0.
